// File: rtl/instr_decode_stage_pkg.sv
// Shared decode types: instruction formats, RV opcodes and the decoded entry record.
// The decoded_t pc/imm fields are sized for the widest legal XLEN; stages slice them down.
package decode_pkg;

    localparam int XLEN_MAX    = 64;
    localparam int REG_FIELD_W = 5;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;

    typedef struct packed {
        logic [XLEN_MAX-1:0]    pc;
        fmt_e                   fmt;
        logic [6:0]             opcode;
        logic [2:0]             funct3;
        logic [6:0]             funct7;
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
        logic [REG_FIELD_W-1:0] rd;
        logic [XLEN_MAX-1:0]    imm;
        logic                   illegal;
    } decoded_t;

    // The 32-bit-word opcodes only exist on RV64.
    function automatic fmt_e opcode_fmt(input logic [6:0] opcode, input logic rv64);
        fmt_e fmt;
        case (opcode)
            OP_LUI, OP_AUIPC:                   fmt = FMT_U;
            OP_JAL:                             fmt = FMT_J;
            OP_BRANCH:                          fmt = FMT_B;
            OP_STORE:                           fmt = FMT_S;
            OP_REG:                             fmt = FMT_R;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_FENCE, OP_SYSTEM:                fmt = FMT_I;
            OP_IMM_32:                          fmt = rv64 ? FMT_I : FMT_ILLEGAL;
            OP_REG_32:                          fmt = rv64 ? FMT_R : FMT_ILLEGAL;
            default:                            fmt = FMT_ILLEGAL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Build the 32-bit immediate first, then sign-extend to XLEN from bit 31.
    always_comb begin
        fmt     = (instr[1:0] == 2'b11) ? opcode_fmt(instr[6:0], XLEN == 64) : FMT_ILLEGAL;
        illegal = (fmt == FMT_ILLEGAL);
        imm32   = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer so in_ready is a flop.
// Optional DECODE_ILLEGAL_CNT_EN adds a saturating count of accepted illegal instructions.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output fmt_e              out_fmt,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0]  illegal_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

    state_e    state_q, state_d;
    decoded_t  out_q, out_d;
    decoded_t  skid_q, skid_d;
    logic      out_valid_q, out_valid_d;
    logic      in_ready_q, in_ready_d;

    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    decoded_t        dec;
    logic            in_fire;
    logic            out_fire;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .illegal (dec_illegal),
        .imm     (dec_imm)
    );

    always_comb begin
        dec         = '0;
        dec.pc      = XLEN_MAX'(in_pc);
        dec.fmt     = dec_fmt;
        dec.opcode  = in_instr[6:0];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.imm     = XLEN_MAX'($signed(dec_imm));
        dec.illegal = dec_illegal;
    end

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Skid occupancy: ST_FULL means both output and skid registers hold entries.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_d  = dec;
                        state_d = ST_FULL;
                    end else if (in_fire && out_fire) begin
                        out_d = dec;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc[XLEN-1:0];
    assign out_fmt     = out_q.fmt;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rs1     = REG_AW'(out_q.rs1);
    assign out_rs2     = REG_AW'(out_q.rs2);
    assign out_rd      = REG_AW'(out_q.rd);
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_illegal = out_q.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // Counts only instructions that really enter the stage; flush leaves the count alone.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (!flush && in_fire && dec_illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed decodes, backpressure, flush and a random scoreboard run.
module tb_instr_decode_stage;
    import decode_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef DECODE_ILLEGAL_CNT_EN
    localparam int CNT_W  = 2;
`else
    localparam int CNT_W  = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    fmt_e              out_fmt;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_imm;
    logic              out_illegal;
`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0]  illegal_cnt;
`endif

    instr_decode_stage #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_fmt     (out_fmt),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
`ifdef DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    fmt_e fmt_map [bit [6:0]];
    exp_t sb_q [$];

    // Reference decode: immediate value computed as a signed integer from the bit fields.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        exp_t   e;
        longint rest;
        longint weight;
        longint v;
        e.pc     = pc;
        e.opcode = instr[6:0];
        e.funct3 = instr[14:12];
        e.funct7 = instr[31:25];
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.rd     = instr[11:7];
        if (instr[1:0] == 2'b11 && fmt_map.exists(instr[6:0])) e.fmt = fmt_map[instr[6:0]];
        else e.fmt = FMT_ILLEGAL;
        e.illegal = (e.fmt == FMT_ILLEGAL);
        rest   = 0;
        weight = 0;
        case (e.fmt)
            FMT_I: begin rest = longint'(instr[30:20]); weight = 2048; end
            FMT_S: begin rest = longint'(instr[30:25]) * 32 + longint'(instr[11:7]); weight = 2048; end
            FMT_B: begin
                rest = longint'(instr[7]) * 2048 + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
                weight = 4096;
            end
            FMT_U: begin rest = longint'(instr[30:12]) * 4096; weight = 64'sd2147483648; end
            FMT_J: begin
                rest = longint'(instr[19:12]) * 4096 + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
                weight = 1048576;
            end
            default: ;
        endcase
        v = instr[31] ? rest - weight : rest;
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    function automatic exp_t sample_out();
        exp_t s;
        s.pc      = out_pc;
        s.fmt     = out_fmt;
        s.opcode  = out_opcode;
        s.funct3  = out_funct3;
        s.funct7  = out_funct7;
        s.rs1     = out_rs1;
        s.rs2     = out_rs2;
        s.rd      = out_rd;
        s.imm     = out_imm;
        s.illegal = out_illegal;
        return s;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        r = $urandom();
        if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    task automatic send_one(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        @(negedge clk);
        in_instr  = instr;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t zero;
        zero      = '0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (sample_out() !== zero) begin errors++; $display("[TB] FAIL reset_fields: got %h expected %h", sample_out(), zero); end
`ifdef DECODE_ILLEGAL_CNT_EN
        checks++; if (illegal_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc    = 32'h200;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== '0) begin errors++; $display("[TB] FAIL midreset_pc: got %h expected 0", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0]     t_instr [6];
        fmt_e            t_fmt   [6];
        logic [XLEN-1:0] t_imm   [6];
        exp_t            e;
        t_instr = '{32'h00500093, 32'hFE000EE3, 32'h123452B7, 32'h0020A423, 32'h0000007F, 32'h00000010};
        t_fmt   = '{FMT_I, FMT_B, FMT_U, FMT_S, FMT_ILLEGAL, FMT_ILLEGAL};
        t_imm   = '{32'h5, 32'hFFFFFFFC, 32'h12345000, 32'h8, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            send_one(t_instr[i], XLEN'(32'h100 + 4 * i));
            e = ref_decode(t_instr[i], XLEN'(32'h100 + 4 * i));
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (out_fmt !== t_fmt[i]) begin errors++; $display("[TB] FAIL dir%0d_fmt: got %0d expected %0d", i, out_fmt, t_fmt[i]); end
            checks++; if (out_imm !== t_imm[i]) begin errors++; $display("[TB] FAIL dir%0d_imm: got %h expected %h", i, out_imm, t_imm[i]); end
            checks++; if (out_illegal !== (t_fmt[i] == FMT_ILLEGAL)) begin errors++; $display("[TB] FAIL dir%0d_illegal: got %b", i, out_illegal); end
            checks++; if (sample_out() !== e) begin errors++; $display("[TB] FAIL dir%0d_fields: got %h expected %h", i, sample_out(), e); end
            if (i == 0) begin
                checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_pc !== 32'h100) begin
                    errors++; $display("[TB] FAIL addi_regs: got rd=%0d rs1=%0d pc=%h expected rd=1 rs1=0 pc=100", out_rd, out_rs1, out_pc);
                end
            end
            if (i == 2) begin
                checks++; if (out_rd !== 5'd5) begin errors++; $display("[TB] FAIL lui_rd: got %0d expected 5", out_rd); end
            end
            if (i == 3) begin
                checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
                    errors++; $display("[TB] FAIL sw_regs: got rs1=%0d rs2=%0d expected 1 2", out_rs1, out_rs2);
                end
            end
        end
        @(negedge clk);
    endtask

`ifdef DECODE_ILLEGAL_CNT_EN
    task automatic test_illegal_cnt();
        checks++; if (illegal_cnt !== 2'd2) begin errors++; $display("[TB] FAIL cnt_after_dir: got %0d expected 2", illegal_cnt); end
        @(negedge clk);
        in_instr = 32'h0000007F;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (illegal_cnt !== 2'd2) begin errors++; $display("[TB] FAIL cnt_flushed: got %0d expected 2", illegal_cnt); end
        send_one(32'h0000007F, 32'h300);
        checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL cnt_inc: got %0d expected 3", illegal_cnt); end
        send_one(32'h00000010, 32'h304);
        checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL cnt_sat: got %0d expected 3", illegal_cnt); end
        send_one(32'h00500093, 32'h308);
        checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("[TB] FAIL cnt_legal: got %0d expected 3", illegal_cnt); end
        @(negedge clk);
    endtask
`endif

    task automatic test_backpressure();
        exp_t ea, eb, ec;
        logic [31:0] ia, ib, ic;
        ia = rand_instr(); ib = rand_instr(); ic = rand_instr();
        ea = ref_decode(ia, 32'h1000); eb = ref_decode(ib, 32'h1004); ec = ref_decode(ic, 32'h1008);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = ia; in_pc = 32'h1000;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b expected 1", in_ready); end
        checks++; if (sample_out() !== ea || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first: got %h expected %h", sample_out(), ea); end
        in_instr = ib; in_pc = 32'h1004;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2: got %b expected 0", in_ready); end
        in_instr = ic; in_pc = 32'h1008;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready3: got %b expected 0", in_ready); end
        checks++; if (sample_out() !== ea) begin errors++; $display("[TB] FAIL bp_hold: got %h expected %h", sample_out(), ea); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (sample_out() !== eb || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second: got %h expected %h", sample_out(), eb); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready4: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (sample_out() !== ec || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third: got %h expected %h", sample_out(), ec); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        exp_t eg;
        eg = ref_decode(32'h00A00113, 32'h2010);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00100093; in_pc = 32'h2000;
        @(negedge clk);
        in_instr = 32'h00200093; in_pc = 32'h2004;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_full: got %b expected 0", in_ready); end
        in_instr = 32'h00300093; in_pc = 32'h2008;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_ready: got %b expected 1", in_ready); end
        in_instr = 32'h00400093; in_pc = 32'h200C;
        @(negedge clk);
        in_instr = 32'h00500093; in_pc = 32'h2010;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_hs_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_hs_ready: got %b expected 1", in_ready); end
        send_one(32'h00A00113, 32'h2010);
        checks++; if (sample_out() !== eg || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fl_next: got %h expected %h", sample_out(), eg); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_ghost: got %b expected 0", out_valid); end
    endtask

    // In-order queue model: out_valid iff the queue is non-empty, in_ready iff fewer than two entries.
    task automatic test_random();
        bit   in_fire  = 1'b0;
        bit   out_fire = 1'b0;
        bit   fl       = 1'b0;
        exp_t pend;
        sb_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (fl) sb_q.delete();
            else begin
                if (out_fire) void'(sb_q.pop_front());
                if (in_fire) sb_q.push_back(pend);
            end
            checks++; if (out_valid !== (sb_q.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %b expected %0d", cyc, out_valid, sb_q.size() > 0); end
            checks++; if (in_ready !== (sb_q.size() < 2)) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %0d", cyc, in_ready, sb_q.size() < 2); end
            if (sb_q.size() > 0) begin
                checks++; if (sample_out() !== sb_q[0]) begin errors++; $display("[TB] FAIL rnd_fields c%0d: got %h expected %h", cyc, sample_out(), sb_q[0]); end
            end
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 3);
            in_instr  = rand_instr();
            in_pc     = XLEN'($urandom());
            pend      = ref_decode(in_instr, in_pc);
            fl        = flush;
            in_fire   = in_valid && (sb_q.size() < 2) && !flush;
            out_fire  = (sb_q.size() > 0) && out_ready && !flush;
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        fmt_map[7'b0110111] = FMT_U;
        fmt_map[7'b0010111] = FMT_U;
        fmt_map[7'b1101111] = FMT_J;
        fmt_map[7'b1100011] = FMT_B;
        fmt_map[7'b0100011] = FMT_S;
        fmt_map[7'b0110011] = FMT_R;
        fmt_map[7'b1100111] = FMT_I;
        fmt_map[7'b0000011] = FMT_I;
        fmt_map[7'b0010011] = FMT_I;
        fmt_map[7'b0001111] = FMT_I;
        fmt_map[7'b1110011] = FMT_I;
        if (XLEN == 64) begin
            fmt_map[7'b0011011] = FMT_I;
            fmt_map[7'b0111011] = FMT_R;
        end
        $display("[TB] starting instr_decode_stage bench");
        test_reset();
        test_directed();
`ifdef DECODE_ILLEGAL_CNT_EN
        test_illegal_cnt();
`endif
        test_backpressure();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
